// File: rtl/alu_share_arbiter_pkg.sv
// alu_pkg: opcode and buffer-state types shared by the ALU and the arbiter
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_SLL  = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001
    } alu_op_t;

    localparam logic [3:0] ALU_OP_MAX = 4'b1001;

    typedef enum logic {EMPTY, FULL} buf_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request and response bundle between requesters and the shared ALU
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [4*NUM_REQ-1:0]  req_alu_control;
    logic [NUM_REQ-1:0]    req_alu_src;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_result;
    logic                  resp_equal;
    logic                  resp_less_than;
    logic                  resp_less_than_unsigned;
    logic                  illegal_op;

    modport master (
        output req_valid, req_alu_control, req_alu_src, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_equal,
               resp_less_than, resp_less_than_unsigned, illegal_op
    );

    modport slave (
        input  req_valid, req_alu_control, req_alu_src, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_equal,
               resp_less_than, resp_less_than_unsigned, illegal_op
    );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// alu: combinational integer ALU with compare flags computed for every opcode
module alu
    import alu_pkg::*;
(
    input  logic [3:0]  alu_control,
    input  logic        alu_src,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        equal,
    output logic        less_than,
    output logic        less_than_unsigned
);
    logic [31:0] shamt;

    // immediates shift by their low five bits; register operands shift by the full value
    assign shamt              = alu_src ? {27'b0, b[4:0]} : b;
    assign equal              = a == b;
    assign less_than          = $signed(a) < $signed(b);
    assign less_than_unsigned = a < b;

    // opcode decode; unmapped opcodes yield zero
    always_comb begin
        result = '0;
        case (alu_control)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLT:  result = {31'b0, less_than};
            OP_SLTU: result = {31'b0, less_than_unsigned};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU with a single-entry tagged response buffer
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);
    buf_state_t      state_q, state_d;
    logic [ID_W-1:0] prio_ptr, sel;
    logic            can_accept, grant;
    int              idx;
    logic [3:0]      op;
    logic [31:0]     alu_result;
    logic            alu_eq, alu_lt, alu_ltu;

    assign can_accept = rst_n && (state_q == EMPTY || bus.resp_ready);
    assign op         = bus.req_alu_control[4*sel +: 4];

    // round-robin search starting at prio_ptr; only one requester is granted
    always_comb begin
        bus.req_ready = '0;
        sel           = '0;
        grant         = 1'b0;
        idx           = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(prio_ptr) + k) % NUM_REQ;
            if (can_accept && !grant && bus.req_valid[idx]) begin
                grant              = 1'b1;
                bus.req_ready[idx] = 1'b1;
                sel                = ID_W'(idx);
            end
        end
    end

    alu u_alu (
        .alu_control        (op),
        .alu_src            (bus.req_alu_src[sel]),
        .a                  (bus.req_a[32*sel +: 32]),
        .b                  (bus.req_b[32*sel +: 32]),
        .result             (alu_result),
        .equal              (alu_eq),
        .less_than          (alu_lt),
        .less_than_unsigned (alu_ltu)
    );

    // buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // a grant always fills the buffer; a drain without a grant empties it
    always_comb begin
        state_d        = state_q;
        bus.resp_valid = state_q == FULL;
        if (grant)                               state_d = FULL;
        else if (state_q == FULL && bus.resp_ready) state_d = EMPTY;
    end

    // response payload, priority pointer and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_id                 <= '0;
            bus.resp_result             <= '0;
            bus.resp_equal              <= 1'b0;
            bus.resp_less_than          <= 1'b0;
            bus.resp_less_than_unsigned <= 1'b0;
            bus.illegal_op              <= 1'b0;
            prio_ptr                    <= '0;
        end else if (grant) begin
            bus.resp_id                 <= sel;
            bus.resp_result             <= alu_result;
            bus.resp_equal              <= alu_eq;
            bus.resp_less_than          <= alu_lt;
            bus.resp_less_than_unsigned <= alu_ltu;
            bus.illegal_op              <= bus.illegal_op || (op > ALU_OP_MAX);
            prio_ptr                    <= ID_W'((int'(sel) + 1) % NUM_REQ);
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of arbitration, buffering, ALU ops and reset
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    alu_share_arbiter_if #(.NUM_REQ(2)) bus ();

    alu_share_arbiter #(.NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic src,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_alu_control[4*i +: 4] = op;
        bus.req_alu_src[i]            = src;
        bus.req_a[32*i +: 32]         = a;
        bus.req_b[32*i +: 32]         = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req_valid       = '0;
        bus.req_alu_control = '0;
        bus.req_alu_src     = '0;
        bus.req_a           = '0;
        bus.req_b           = '0;
        bus.resp_ready      = 1'b1;

        // reset state, with a request pending that must not be granted
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_id", 32'(bus.resp_id), 32'h0);
        chk("rst_result", bus.resp_result, 32'h0);
        chk("rst_flags", {29'b0, bus.resp_equal, bus.resp_less_than, bus.resp_less_than_unsigned}, 32'h0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'h0);
        bus.req_valid = 2'b00;
        #2 rst_n = 1'b1;

        // single request: add 5+7
        @(negedge clk);
        set_req(0, 4'b0000, 1'b0, 32'd5, 32'd7);
        bus.req_valid = 2'b01;
        #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("single_valid", 32'(bus.resp_valid), 32'h1);
        chk("single_id", 32'(bus.resp_id), 32'h0);
        chk("single_result", bus.resp_result, 32'd12);
        chk("single_equal", 32'(bus.resp_equal), 32'h0);

        // contention right after reset: req0 first, then req1
        do_reset();
        set_req(0, 4'b0001, 1'b0, 32'd3, 32'd3);
        set_req(1, 4'b1001, 1'b0, 32'd1, 32'd2);
        bus.req_valid = 2'b11;
        #1 chk("cont_ready0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b10;
        chk("cont_id0", 32'(bus.resp_id), 32'h0);
        chk("cont_result0", bus.resp_result, 32'h0);
        chk("cont_equal0", 32'(bus.resp_equal), 32'h1);
        #1 chk("cont_ready1", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("cont_id1", 32'(bus.resp_id), 32'h1);
        chk("cont_result1", bus.resp_result, 32'h1);
        chk("cont_ltu1", 32'(bus.resp_less_than_unsigned), 32'h1);
        chk("cont_lt1", 32'(bus.resp_less_than), 32'h1);

        // backpressure holds the buffer and blocks grants
        bus.resp_ready = 1'b0;
        set_req(1, 4'b0000, 1'b0, 32'd10, 32'd20);
        bus.req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_valid", 32'(bus.resp_valid), 32'h1);
            chk("bp_id", 32'(bus.resp_id), 32'h1);
            chk("bp_result", bus.resp_result, 32'h1);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("bp_new_valid", 32'(bus.resp_valid), 32'h1);
        chk("bp_new_id", 32'(bus.resp_id), 32'h1);
        chk("bp_new_result", bus.resp_result, 32'd30);
        @(negedge clk);
        chk("drain_empty", 32'(bus.resp_valid), 32'h0);

        // streaming with alternating fair grants
        set_req(0, 4'b0000, 1'b0, 32'd100, 32'd1);
        set_req(1, 4'b0000, 1'b0, 32'd200, 32'd2);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(bus.resp_valid), 32'h1);
            chk("stream_id", 32'(bus.resp_id), 32'(k % 2));
            chk("stream_result", bus.resp_result, (k % 2) ? 32'd202 : 32'd101);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // arithmetic shift: immediate uses B[4:0], register uses the full B
        set_req(0, 4'b0111, 1'b1, 32'h8000_0000, 32'h21);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("sra_imm", bus.resp_result, 32'hC000_0000);
        set_req(0, 4'b0111, 1'b0, 32'h8000_0000, 32'h21);
        @(negedge clk);
        chk("sra_reg", bus.resp_result, 32'hFFFF_FFFF);
        set_req(0, 4'b0101, 1'b1, 32'h0000_0003, 32'h24);
        @(negedge clk);
        chk("sll_imm", bus.resp_result, 32'h0000_0030);

        // illegal opcode returns zero and sets the sticky flag
        set_req(0, 4'b1100, 1'b0, 32'd5, 32'd5);
        @(negedge clk);
        chk("illegal_result", bus.resp_result, 32'h0);
        chk("illegal_flag", 32'(bus.illegal_op), 32'h1);
        chk("illegal_equal", 32'(bus.resp_equal), 32'h1);
        set_req(0, 4'b0010, 1'b0, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.resp_ready = 1'b0;
        chk("xor_result", bus.resp_result, 32'h0000_00FF);
        chk("illegal_sticky", 32'(bus.illegal_op), 32'h1);

        // asynchronous reset while FULL clears everything before the next edge
        bus.req_valid = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.resp_valid), 32'h0);
        chk("async_illegal", 32'(bus.illegal_op), 32'h0);
        chk("async_result", bus.resp_result, 32'h0);
        chk("async_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 2'b00;
        #1 rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
